// File: rtl/change_dispenser.sv
// change_dispenser: breaks a change-due amount greedily into 5/2/1 rupee coins
// and feeds a coin hopper one coin at a time over a valid/ack handshake, while
// tracking per-denomination inventory.
// Optional feature macro: CHANGE_ACK_TIMEOUT_EN (ack-wait timeout -> jam fault).
module change_dispenser #(
    parameter int AMT_W       = 4,
    parameter int CNT_W       = 4,
    parameter int INIT_CNT1   = 8,
    parameter int INIT_CNT2   = 8,
    parameter int INIT_CNT5   = 8,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    input  logic [AMT_W-1:0] req_amount,
    output logic             req_ready,
    output logic [2:0]       coin_out,
    output logic             coin_valid,
    input  logic             coin_ack,
    input  logic             refill_valid,
    input  logic [2:0]       refill_coin,
    output logic             busy,
    output logic             done,
    output logic [1:0]       fault_code,
    output logic [AMT_W-1:0] remaining,
    output logic [CNT_W-1:0] cnt1,
    output logic [CNT_W-1:0] cnt2,
    output logic [CNT_W-1:0] cnt5
);
    localparam logic [2:0] C1 = 3'b001;
    localparam logic [2:0] C2 = 3'b010;
    localparam logic [2:0] C5 = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_ISSUE, S_GAP, S_DONE, S_FAULT
    } state_t;

    state_t           state, state_nxt;
    logic [2:0]       pick, pick_nxt;
    logic [AMT_W-1:0] rem_nxt;
    logic [1:0]       fault_nxt;
    logic             refill_ok, take;
    logic             inc1, inc2, inc5, dec1, dec2, dec5;
    logic             tmo_hit;

    // Face value of a coin code; only ever called with a valid code.
    function automatic logic [AMT_W-1:0] coin_val(input logic [2:0] code);
        case (code)
            C5:      coin_val = AMT_W'(5);
            C2:      coin_val = AMT_W'(2);
            default: coin_val = AMT_W'(1);
        endcase
    endfunction

    // Saturating up, plain down; simultaneous inc/dec cancel out.
    function automatic logic [CNT_W-1:0] cnt_upd(input logic [CNT_W-1:0] c,
                                                 input logic inc, input logic dec);
        if (inc && !dec && c != '1)
            cnt_upd = c + 1'b1;
        else if (dec && !inc)
            cnt_upd = c - 1'b1;
        else
            cnt_upd = c;
    endfunction

    assign refill_ok = refill_valid && (refill_coin == C1 || refill_coin == C2 || refill_coin == C5);
    assign take      = (state == S_ISSUE) && coin_ack;
    assign inc1      = refill_ok && refill_coin == C1;
    assign inc2      = refill_ok && refill_coin == C2;
    assign inc5      = refill_ok && refill_coin == C5;
    assign dec1      = take && pick == C1;
    assign dec2      = take && pick == C2;
    assign dec5      = take && pick == C5;

`ifdef CHANGE_ACK_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo;

    // Count consecutive ack-less ISSUE cycles; cleared whenever ISSUE is (re)entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tmo <= '0;
        else if (state == S_ISSUE && state_nxt == S_ISSUE)
            tmo <= tmo + 1'b1;
        else
            tmo <= '0;
    end

    assign tmo_hit = (tmo == TMO_W'(TIMEOUT_CYC - 1));
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYC != 0);
    assign tmo_hit    = 1'b0;
`endif

    // Next-state, greedy coin selection and balance/fault bookkeeping.
    always_comb begin
        state_nxt = state;
        pick_nxt  = pick;
        rem_nxt   = remaining;
        fault_nxt = fault_code;
        case (state)
            S_IDLE: if (req_valid) begin
                rem_nxt   = req_amount;
                state_nxt = S_SELECT;
            end
            S_SELECT: begin
                if (remaining == '0) begin
                    state_nxt = S_DONE;
                end else if (remaining >= AMT_W'(5) && cnt5 != '0) begin
                    pick_nxt  = C5;
                    state_nxt = S_ISSUE;
                end else if (remaining >= AMT_W'(2) && cnt2 != '0) begin
                    pick_nxt  = C2;
                    state_nxt = S_ISSUE;
                end else if (cnt1 != '0) begin
                    pick_nxt  = C1;
                    state_nxt = S_ISSUE;
                end else begin
                    fault_nxt = 2'b01;
                    state_nxt = S_FAULT;
                end
            end
            S_ISSUE: begin
                if (coin_ack) begin
                    rem_nxt   = remaining - coin_val(pick);
                    state_nxt = S_GAP;
                end else if (tmo_hit) begin
                    fault_nxt = 2'b10;
                    state_nxt = S_FAULT;
                end
            end
            S_GAP:  state_nxt = S_SELECT;
            S_DONE: state_nxt = S_IDLE;
            S_FAULT: if (refill_ok) begin
                fault_nxt = 2'b00;
                state_nxt = S_SELECT;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, inventory and registered Moore outputs derived from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            pick       <= C1;
            remaining  <= '0;
            fault_code <= 2'b00;
            cnt1       <= CNT_W'(INIT_CNT1);
            cnt2       <= CNT_W'(INIT_CNT2);
            cnt5       <= CNT_W'(INIT_CNT5);
            coin_valid <= 1'b0;
            coin_out   <= 3'b000;
            done       <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            pick       <= pick_nxt;
            remaining  <= rem_nxt;
            fault_code <= fault_nxt;
            cnt1       <= cnt_upd(cnt1, inc1, dec1);
            cnt2       <= cnt_upd(cnt2, inc2, dec2);
            cnt5       <= cnt_upd(cnt5, inc5, dec5);
            coin_valid <= (state_nxt == S_ISSUE);
            coin_out   <= (state_nxt == S_ISSUE) ? pick_nxt : 3'b000;
            done       <= (state_nxt == S_DONE);
            req_ready  <= (state_nxt == S_IDLE);
            busy       <= (state_nxt != S_IDLE);
        end
    end
endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: transaction-level greedy-change model acting as the
// hopper, with a second instance built with empty 1/2 rupee inventory.
module tb_change_dispenser;
    typedef struct packed {
        logic       req_ready;
        logic [2:0] coin_out;
        logic       coin_valid;
        logic       busy;
        logic       done;
        logic [1:0] fault_code;
        logic [3:0] remaining;
        logic [3:0] cnt1;
        logic [3:0] cnt2;
        logic [3:0] cnt5;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid, coin_ack, refill_valid;
    logic [3:0] req_amount;
    logic [2:0] refill_coin;
    obs_t       oa, ob, v;
    int         sel;
    int         errs = 0, checks = 0;
    int         m1, m2, m5;

    always #5 clk = ~clk;

    change_dispenser dut_a (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_amount(req_amount),
        .req_ready(oa.req_ready), .coin_out(oa.coin_out), .coin_valid(oa.coin_valid),
        .coin_ack(coin_ack), .refill_valid(refill_valid), .refill_coin(refill_coin),
        .busy(oa.busy), .done(oa.done), .fault_code(oa.fault_code), .remaining(oa.remaining),
        .cnt1(oa.cnt1), .cnt2(oa.cnt2), .cnt5(oa.cnt5));

    change_dispenser #(.INIT_CNT1(0), .INIT_CNT2(0)) dut_b (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_amount(req_amount),
        .req_ready(ob.req_ready), .coin_out(ob.coin_out), .coin_valid(ob.coin_valid),
        .coin_ack(coin_ack), .refill_valid(refill_valid), .refill_coin(refill_coin),
        .busy(ob.busy), .done(ob.done), .fault_code(ob.fault_code), .remaining(ob.remaining),
        .cnt1(ob.cnt1), .cnt2(ob.cnt2), .cnt5(ob.cnt5));

    // Observe whichever instance the current test is about.
    always_comb v = (sel != 0) ? ob : oa;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Inventory model: a valid coin adds one, capped at 15; other codes do nothing.
    task automatic model_refill(input int code);
        if (code == 1) m1 = (m1 < 15) ? m1 + 1 : 15;
        if (code == 2) m2 = (m2 < 15) ? m2 + 1 : 15;
        if (code == 5) m5 = (m5 < 15) ? m5 + 1 : 15;
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_c1"}, v.cnt1, m1);
        chk({tag, "_c2"}, v.cnt2, m2);
        chk({tag, "_c5"}, v.cnt5, m5);
    endtask

    // Pay one request end to end, acting as hopper. fcode: refill used to leave a
    // short fault (0 = random valid coin). noisy: random refills/requests while waiting.
    task automatic run_req(input int amt, input int dmin, input int dmax,
                           input int fcode, input bit noisy);
        int rem, coin, d, code;
        bit fin;
        rem = amt;
        fin = 0;
        chk("ready_idle", v.req_ready, 1);
        req_valid = 1'b1; req_amount = 4'(amt);
        @(negedge clk);
        req_valid = 1'b0;
        chk("busy_sel", v.busy, 1);
        for (int g = 0; g < 64 && !fin; g++) begin
            coin = (rem >= 5 && m5 > 0) ? 5 : (rem >= 2 && m2 > 0) ? 2 : (m1 > 0) ? 1 : 0;
            if (rem == 0) begin
                @(negedge clk);
                chk("done_hi", v.done, 1);
                chk("done_rem", v.remaining, 0);
                chk("done_cv", v.coin_valid, 0);
                @(negedge clk);
                chk("done_lo", v.done, 0);
                chk("ready_after", v.req_ready, 1);
                chk("fault_end", v.fault_code, 0);
                chk_counts("end");
                fin = 1;
            end else if (coin == 0) begin
                @(negedge clk);
                chk("short_code", v.fault_code, 1);
                chk("short_rem", v.remaining, rem);
                chk("short_cv", v.coin_valid, 0);
                refill_valid = 1'b1; refill_coin = 3'b011;
                @(negedge clk);
                refill_valid = 1'b0;
                chk("bad_refill_hold", v.fault_code, 1);
                code = (fcode != 0) ? fcode : ($urandom_range(2, 0) == 0 ? 1 : $urandom_range(1, 0) == 0 ? 2 : 5);
                refill_valid = 1'b1; refill_coin = 3'(code);
                @(negedge clk);
                refill_valid = 1'b0;
                model_refill(code);
                chk("resume_clr", v.fault_code, 0);
            end else begin
                @(negedge clk);
                chk("issue_cv", v.coin_valid, 1);
                chk("issue_code", v.coin_out, coin);
                chk("issue_rem", v.remaining, rem);
                d = $urandom_range(dmax, dmin);
                for (int i = 0; i < d; i++) begin
                    if (noisy && $urandom_range(3, 0) == 0) begin
                        refill_valid = 1'b1; refill_coin = 3'($urandom_range(7, 0));
                    end
                    if (noisy && $urandom_range(3, 0) == 0) begin
                        req_valid = 1'b1; req_amount = 4'($urandom_range(15, 0));
                    end
                    @(negedge clk);
                    if (refill_valid) model_refill(int'(refill_coin));
                    refill_valid = 1'b0; req_valid = 1'b0;
                    chk("wait_cv", v.coin_valid, 1);
                    chk("wait_code", v.coin_out, coin);
                end
                coin_ack = 1'b1;
                if (noisy && $urandom_range(2, 0) == 0) begin
                    refill_valid = 1'b1; refill_coin = 3'(coin);
                end
                @(negedge clk);
                coin_ack = 1'b0;
                rem -= coin;
                if (coin == 1) m1--;
                if (coin == 2) m2--;
                if (coin == 5) m5--;
                if (refill_valid) model_refill(int'(refill_coin));
                refill_valid = 1'b0;
                chk("gap_cv", v.coin_valid, 0);
                chk("gap_code", v.coin_out, 0);
                chk("gap_rem", v.remaining, rem);
                @(negedge clk);
            end
        end
        if (!fin) chk("req_bound", 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m1 = 8; m2 = 8; m5 = 8;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_amount = '0; coin_ack = 1'b0;
        refill_valid = 1'b0; refill_coin = '0; sel = 0;
        m1 = 8; m2 = 8; m5 = 8;
        repeat (2) @(negedge clk);
        chk("rst_ready", v.req_ready, 1);
        chk("rst_busy", v.busy, 0);
        chk("rst_cv", v.coin_valid, 0);
        chk("rst_code", v.coin_out, 0);
        chk("rst_done", v.done, 0);
        chk("rst_fault", v.fault_code, 0);
        chk("rst_rem", v.remaining, 0);
        chk_counts("rst");
        reset = 1'b1;
        @(negedge clk);

        // Empty 1/2 inventory: 6 -> one 5, short by 1, refill 1 pays the rest.
        sel = 1; m1 = 0; m2 = 0; m5 = 8;
        run_req(6, 1, 1, 1, 0);
        chk("b_c5", v.cnt5, 7);
        chk("b_c1", v.cnt1, 0);

        sel = 0;
        do_reset();
        run_req(3, 1, 1, 0, 0);
        chk("a3_c2", v.cnt2, 7);
        chk("a3_c1", v.cnt1, 7);
        run_req(7, 1, 1, 0, 0);
        run_req(0, 0, 0, 0, 0);
        run_req(4, 10, 10, 0, 0);

        // Reset while a coin is presented.
        req_valid = 1'b1; req_amount = 4'd5;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("mid_cv_before", v.coin_valid, 1);
        #2 reset = 1'b0;
        #1;
        m1 = 8; m2 = 8; m5 = 8;
        chk("mid_cv_rst", v.coin_valid, 0);
        chk_counts("mid");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_ready", v.req_ready, 1);
        chk("mid_cv_after", v.coin_valid, 0);

        // Long ack silence on a 5 rupee coin.
        req_valid = 1'b1; req_amount = 4'd5;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("silent_code", v.coin_out, 5);
`ifdef CHANGE_ACK_TIMEOUT_EN
        repeat (15) @(negedge clk);
        chk("tmo_pre_cv", v.coin_valid, 1);
        @(negedge clk);
        chk("tmo_fault", v.fault_code, 2);
        chk("tmo_cv", v.coin_valid, 0);
        chk("tmo_rem", v.remaining, 5);
        chk("tmo_c5", v.cnt5, m5);
        refill_valid = 1'b1; refill_coin = 3'b011;
        @(negedge clk);
        refill_valid = 1'b0;
        chk("tmo_bad_refill", v.fault_code, 2);
        refill_valid = 1'b1; refill_coin = 3'b001;
        @(negedge clk);
        refill_valid = 1'b0;
        model_refill(1);
        chk("tmo_resume", v.fault_code, 0);
        @(negedge clk);
`else
        repeat (20) @(negedge clk);
        chk("silent_fault", v.fault_code, 0);
`endif
        chk("silent_cv", v.coin_valid, 1);
        chk("silent_code2", v.coin_out, 5);
        coin_ack = 1'b1;
        @(negedge clk);
        coin_ack = 1'b0;
        m5--;
        chk("silent_gap", v.coin_valid, 0);
        repeat (2) @(negedge clk);
        chk("silent_done", v.done, 1);
        @(negedge clk);
        chk_counts("silent");

        // Random requests, ack delays, stray refills and ignored requests.
        for (int n = 0; n < 40; n++)
            run_req($urandom_range(15, 0), 0, 3, 0, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Coin-emitting counterpart to the Moore vending controller's coin-accepting path.
- Accepts a change-due request (₹ amount), breaks it greedily into 5₹/2₹/1₹ coins, and drives a coin hopper one coin at a time over a valid/ack handshake.
- Tracks per-denomination coin inventory and flags a fault when the request cannot be paid.
- Uses the same 3-bit coin code as the acceptor side: 3'b001 = 1₹, 3'b010 = 2₹, 3'b101 = 5₹.

Parameters:
- AMT_W, 4, width of change request and remaining amount.
- CNT_W, 4, width of each inventory counter; counters saturate at 2^CNT_W-1.
- INIT_CNT1, 8, 1₹ coins loaded at reset.
- INIT_CNT2, 8, 2₹ coins loaded at reset.
- INIT_CNT5, 8, 5₹ coins loaded at reset.
- TIMEOUT_CYC, 16, ack-wait limit in cycles; used only with CHANGE_ACK_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  change request strobe.
- req_amount  in  AMT_W  change due, in ₹.
- req_ready  out  1  high only in IDLE.
- coin_out  out  3  coin code presented to the hopper; 3'b000 when idle.
- coin_valid  out  1  hopper request.
- coin_ack  in  1  hopper has ejected the presented coin.
- refill_valid  in  1  one coin added to inventory.
- refill_coin  in  3  code of the coin being added.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the request is fully paid.
- fault_code  out  2  00 none, 01 short (inventory), 10 jam (timeout).
- remaining  out  AMT_W  unpaid balance of the current request.
- cnt1, cnt2, cnt5  out  CNT_W each  inventory counts.

Behaviour:
- Reset (asynchronous, active-low):
  - State IDLE; coin_valid=0, coin_out=000, done=0, fault_code=00, remaining=0.
  - cnt1/cnt2/cnt5 load INIT_CNT1/INIT_CNT2/INIT_CNT5.
  - Reset mid-request abandons the request; no further coins are issued.
- States: IDLE, SELECT, ISSUE, GAP, DONE, FAULT. Outputs are registered.
- IDLE:
  - req_ready=1.
  - req_valid=1 → latch remaining=req_amount and go to SELECT.
  - req_valid while not in IDLE is ignored; no queueing.
- SELECT (1 cycle):
  - remaining==0 → DONE.
  - Else if remaining>=5 and cnt5>0, pick 5₹.
  - Else if remaining>=2 and cnt2>0, pick 2₹.
  - Else if cnt1>0, pick 1₹.
  - Else go to FAULT with fault_code=01.
  - A picked coin → ISSUE.
  - Greedy only; no backtracking. Example: remaining=6, cnt5=1, cnt2=3, cnt1=0 → issues 5₹, then FAULT with remaining=1.
- ISSUE:
  - coin_valid=1; coin_out holds the selected code, stable until ack.
  - On coin_ack=1 (sampled at the rising edge): remaining -= denomination, that count -= 1, go to GAP.
- GAP (1 cycle): coin_valid=0, coin_out=000, then SELECT. This gives a minimum one-cycle low between coins.
- DONE: done=1 for exactly one cycle, then IDLE. remaining stays 0.
- FAULT:
  - fault_code is held and remaining holds the unpaid balance.
  - Any valid refill_valid pulse → SELECT (resume) and fault_code clears to 00.
- coin_ack outside ISSUE is ignored.
- Refill (any state):
  - A valid code increments the matching counter, saturating at max.
  - An invalid code (not 001/010/101) is ignored, including for FAULT exit.
  - Refill and ack-decrement of the same denomination in the same cycle leave the count unchanged.
- Latency: request to first coin_valid is 2 cycles (IDLE→SELECT→ISSUE). Each coin costs ack wait + 2 cycles (GAP, SELECT).

Optional Feature:
- Macro CHANGE_ACK_TIMEOUT_EN.
- Defined:
  - Counter runs in ISSUE.
  - If coin_ack is absent for TIMEOUT_CYC consecutive cycles: go to FAULT, fault_code=10, coin_valid drops, count and remaining unchanged.
  - A refill pulse retries from SELECT.
- Undefined: ISSUE waits indefinitely; fault_code 10 is never produced.

Test Plan:
- Reset with defaults, req_amount=3, ack after 1 cycle each → coins 010 then 001; done pulses once; cnt2=7, cnt1=7; remaining=0.
- req_amount=7 → coins 101, 010; req_amount=0 → done 2 cycles after accept, coin_valid never high.
- INIT_CNT1=0, INIT_CNT2=0, req_amount=6 → 101 issued, then fault_code=01 with remaining=1. Then refill_coin=001 → 001 issued, done, fault_code=00.
- Hold coin_ack low 10 cycles → coin_valid and coin_out stable throughout; ack, then GAP shows coin_valid=0 for 1 cycle.
- Drive reset low mid-ISSUE → coin_valid=0 immediately; counts back to INIT values; req_ready=1 after release.
- With CHANGE_ACK_TIMEOUT_EN, no ack → fault_code=10 after 16 cycles, cnt5 unchanged; refill_coin=011 → stays in FAULT.
